useq_ctrl: RTL
==============

# useq_ctrl

Microsequencer controller that drives the micro-program counter register. Each cycle it decodes the sequencing field of the current microinstruction, the condition flags and a 4-deep return stack. From these it produces the register's `load_incr` / `upc_next` controls, so the counter increments, branches, calls, returns, waits or holds. It sits between the control-store output and the upc register and provides a start/busy/done handshake to the surrounding datapath.

## Interface
Parameters:
- `AW`, 5, micro-address width (matches upc register)
- `DEPTH`, 4, return-stack entries
- `START_ADDR`, 0, entry micro-address loaded on start

Ports:
- `clk`  in  1  system clock, all state on rising edge
- `reset`  in  1  synchronous, active-high; clears all state at the next rising edge
- `start`  in  1  begin a micro-program; sampled only in IDLE
- `upc`  in  AW  current value of the upc register
- `uop`  in  3  sequencing opcode of the microinstruction at `upc`
- `uaddr`  in  AW  branch/call target field of the same microinstruction
- `csel`  in  2  condition select for CJMP
- `cond`  in  4  condition flags from datapath
- `ext_ready`  in  1  external ready, used by WAIT
- `load_incr`  out  1  1 = upc register loads `upc_next`; 0 = upc register increments
- `upc_next`  out  AW  load value for upc register
- `busy`  out  1  high in RUN
- `done`  out  1  one-cycle pulse after END executes
- `err`  out  1  sticky stack fault, high in FAULT

## Operation
- States: IDLE, RUN, FAULT. Reset → IDLE, stack pointer `sp`=0, stack cleared, done=0.
- `load_incr` and `upc_next` are combinational from state, `upc`, `uop`, `uaddr`, `csel`, `cond`, `ext_ready` and stack top. `busy`, `err` decode state. `done` is a register.
- "Hold" means `load_incr`=1 and `upc_next`=`upc`.
- IDLE: if `start`=0, hold. If `start`=1, `load_incr`=1, `upc_next`=START_ADDR, next state RUN.
- RUN, by `uop`:
  - 000 NEXT: `load_incr`=0.
  - 001 JMP: load `uaddr`.
  - 010 CJMP: if `cond[csel]`, load `uaddr`; otherwise `load_incr`=0.
  - 011 CALL: push `upc+1` (mod 2^AW), then load `uaddr`. If `sp`=DEPTH: no push, hold, next state FAULT.
  - 100 RET: pop, load the popped value. If `sp`=0: hold, next state FAULT.
  - 101 WAIT: if `ext_ready`, `load_incr`=0; otherwise hold and stay in RUN.
  - 110 END: hold, next state IDLE, `done`=1 for the following cycle.
  - 111 reserved: behaves as NEXT.
- FAULT: hold every cycle; `err`=1. Only `reset` exits FAULT. `start` is ignored.
- `start` while in RUN or FAULT is ignored.
- Stack is LIFO. `sp` ranges 0..DEPTH. Stack contents are not cleared on END, but `sp` is reset to 0 on END.
- Arithmetic: `upc+1` wraps, 2^AW−1 → 0. CALL at upc=31 pushes 0.

## Timing
- Zero-latency controls: outputs are valid in the same cycle `uop` is presented. The upc register updates at that cycle's rising edge.
- `start` high in IDLE at cycle t: `upc`=START_ADDR and `busy`=1 from cycle t+1. The first `uop` executes in t+1.
- END executed at cycle t: `busy`=0 and `done`=1 in t+1, `done`=0 in t+2. `start` may be accepted in t+1.
- Reset mid-RUN or in FAULT: at the next edge, state=IDLE, `sp`=0, `done`=0, `err`=0, `busy`=0. The upc register is reset by the same `reset` line.
- Reset has priority over every other input in the same cycle.

## Test plan
- Reset, then IDLE with `start`=0 for 5 cycles → `load_incr`=1, `upc_next`=`upc`, `busy`=0, upc constant at 0.
- `start` pulse; program 0:NEXT, 1:NEXT, 2:JMP 7, 7:END → upc sequence 0,1,2,7,7. `done` pulses one cycle after END and `busy` falls with it.
- CJMP at 3 targeting 10 with `csel`=2: `cond`=4'b0100 → upc=10; `cond`=4'b0000 → upc=4.
- CALL 20 at upc=5, 20:NEXT, 21:RET → upc 5,20,21,6. `sp` returns to 0. Nested CALLs to depth 4 then RETs return in reverse order.
- Fault cases: a 5th nested CALL → hold, `err`=1, `busy`=0, and `start` ignored until reset. RET with `sp`=0 → FAULT the same way. `reset` clears `err` the next cycle.
- Wait and wrap: WAIT with `ext_ready`=0 for 3 cycles holds upc, then `ext_ready`=1 advances upc by 1 the next cycle. NEXT at upc=31 → upc=0.

Source files
------------

// File: rtl/useq_ctrl.sv
// Microsequencer controller: decodes the sequencing opcode, condition flags and a
// small return stack into load/next-address controls for an external upc register.
module useq_ctrl #(
  parameter int unsigned    AW         = 5,
  parameter int unsigned    DEPTH      = 4,
  parameter logic [AW-1:0]  START_ADDR = '0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [AW-1:0] upc,
  input  logic [2:0]    uop,
  input  logic [AW-1:0] uaddr,
  input  logic [1:0]    csel,
  input  logic [3:0]    cond,
  input  logic          ext_ready,
  output logic          load_incr,
  output logic [AW-1:0] upc_next,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam int unsigned SPW = $clog2(DEPTH + 1);
  localparam int unsigned IW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [SPW-1:0] SP_FULL = SPW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FAULT} state_e;

  typedef enum logic [2:0] {
    OP_NEXT = 3'b000,
    OP_JMP  = 3'b001,
    OP_CJMP = 3'b010,
    OP_CALL = 3'b011,
    OP_RET  = 3'b100,
    OP_WAIT = 3'b101,
    OP_END  = 3'b110,
    OP_RSVD = 3'b111
  } uop_e;

  state_e         state_q, state_d;
  logic [SPW-1:0] sp_q, sp_d;
  logic           done_q, done_d;
  logic [AW-1:0]  stack_q [DEPTH];

  logic           push;
  logic [AW-1:0]  upc_inc;
  logic [IW-1:0]  push_idx, top_idx;

  assign upc_inc  = upc + 1'b1;
  assign push_idx = IW'(sp_q);
  // top_idx is only used when sp_q > 0, so the underflow at sp_q == 0 is harmless
  assign top_idx  = IW'(sp_q - 1'b1);

  always_comb begin
    state_d   = state_q;
    sp_d      = sp_q;
    done_d    = 1'b0;
    push      = 1'b0;
    load_incr = 1'b1;
    upc_next  = upc;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          upc_next = START_ADDR;
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        case (uop_e'(uop))
          OP_NEXT, OP_RSVD: load_incr = 1'b0;
          OP_JMP:           upc_next  = uaddr;
          OP_CJMP: begin
            if (cond[csel]) upc_next  = uaddr;
            else            load_incr = 1'b0;
          end
          OP_CALL: begin
            if (sp_q == SP_FULL) begin
              state_d = S_FAULT;
            end else begin
              push     = 1'b1;
              sp_d     = sp_q + 1'b1;
              upc_next = uaddr;
            end
          end
          OP_RET: begin
            if (sp_q == '0) begin
              state_d = S_FAULT;
            end else begin
              sp_d     = sp_q - 1'b1;
              upc_next = stack_q[top_idx];
            end
          end
          OP_WAIT: begin
            if (ext_ready) load_incr = 1'b0;
          end
          OP_END: begin
            state_d = S_IDLE;
            sp_d    = '0;
            done_d  = 1'b1;
          end
          default: load_incr = 1'b0;
        endcase
      end
      S_FAULT: ;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      sp_q    <= '0;
      done_q  <= 1'b0;
      for (int unsigned i = 0; i < DEPTH; i++) stack_q[i] <= '0;
    end else begin
      state_q <= state_d;
      sp_q    <= sp_d;
      done_q  <= done_d;
      if (push) stack_q[push_idx] <= upc_inc;
    end
  end

  assign busy = (state_q == S_RUN);
  assign err  = (state_q == S_FAULT);
  assign done = done_q;

endmodule
